// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//   Per-channel conditioner for slide switches and push-buttons. Each raw
//   switch level is brought into the Clk domain through a two-flop
//   synchroniser. A per-channel stability counter then qualifies every new
//   level. Once a level is accepted the block drives a clean registered level
//   and a one-cycle rise or fall pulse.
//
// Parameters
//   WIDTH          number of independent channels
//   STABLE_CYCLES  consecutive synchronised samples needed to accept a level
//                  (legal range 2 .. 2**CNT_W-1)
//   CNT_W          width of each channel's stability counter
//
// Ports
//   Clk    in   1      system clock, rising edge
//   Reset  in   1      asynchronous, active-high reset
//   SW     in   WIDTH  raw, asynchronous switch levels
//   Q      out  WIDTH  debounced level (registered)
//   Rise   out  WIDTH  one-cycle pulse when Q goes 0->1 (registered)
//   Fall   out  WIDTH  one-cycle pulse when Q goes 1->0 (registered)
//   Busy   out  WIDTH  channel is qualifying a candidate level
//   Tog    out  WIDTH  toggle-per-press register
//
// Build option
//   SW_DEBOUNCE_TOGGLE_EN  when defined, Tog[i] inverts on every Rise[i].
//                          When undefined, Tog is tied to 0 and has no flops.
// -----------------------------------------------------------------------------
module sw_debounce #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic [WIDTH-1:0] Busy,
    output logic [WIDTH-1:0] Tog
);

    // The counter stops at STABLE_CYCLES-1 and never wraps, so
    // STABLE_CYCLES itself only has to fit in CNT_W bits.
    if ((STABLE_CYCLES < 2) ||
        (longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_param
        $error("sw_debounce: STABLE_CYCLES=%0d out of range for CNT_W=%0d",
               STABLE_CYCLES, CNT_W);
    end

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE0 = 2'd0,
        ARM1    = 2'd1,
        STABLE1 = 2'd2,
        ARM0    = 2'd3
    } state_t;

    // ---- stage p0/p1: two-flop synchroniser, SW -> m -> s ----
    logic [WIDTH-1:0] m_p0;
    logic [WIDTH-1:0] s_p1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_p0 <= '0;
            s_p1 <= '0;
        end else begin
            m_p0 <= SW;
            s_p1 <= m_p0;
        end
    end

    // ---- stage p2: per-channel qualification FSM and registered outputs ----
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_t           state_p2, state_nxt;
        logic [CNT_W-1:0] cnt_p2, cnt_nxt;
        logic             q_p2, q_nxt;
        logic             rise_p2, rise_nxt;
        logic             fall_p2, fall_nxt;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state_p2 <= STABLE0;
                cnt_p2   <= '0;
                q_p2     <= 1'b0;
                rise_p2  <= 1'b0;
                fall_p2  <= 1'b0;
            end else begin
                state_p2 <= state_nxt;
                cnt_p2   <= cnt_nxt;
                q_p2     <= q_nxt;
                rise_p2  <= rise_nxt;
                fall_p2  <= fall_nxt;
            end
        end

        // A return to the old level before the commit drops straight back
        // to the stable state, so the next attempt restarts from cnt=1.
        always_comb begin
            state_nxt = state_p2;
            cnt_nxt   = cnt_p2;
            q_nxt     = q_p2;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
            case (state_p2)
                STABLE0: begin
                    if (s_p1[i]) begin
                        state_nxt = ARM1;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                ARM1: begin
                    if (!s_p1[i]) begin
                        state_nxt = STABLE0;
                        cnt_nxt   = '0;
                    end else if (cnt_p2 == CNT_LAST) begin
                        state_nxt = STABLE1;
                        cnt_nxt   = '0;
                        q_nxt     = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt   = cnt_p2 + CNT_ONE;
                    end
                end
                STABLE1: begin
                    if (!s_p1[i]) begin
                        state_nxt = ARM0;
                        cnt_nxt   = CNT_ONE;
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                ARM0: begin
                    if (s_p1[i]) begin
                        state_nxt = STABLE1;
                        cnt_nxt   = '0;
                    end else if (cnt_p2 == CNT_LAST) begin
                        state_nxt = STABLE0;
                        cnt_nxt   = '0;
                        q_nxt     = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt   = cnt_p2 + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = STABLE0;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign Q[i]    = q_p2;
        assign Rise[i] = rise_p2;
        assign Fall[i] = fall_p2;
        // Decoded from the state register only; no path from SW.
        assign Busy[i] = (state_p2 == ARM1) || (state_p2 == ARM0);

`ifdef SW_DEBOUNCE_TOGGLE_EN
        // ---- stage p3: toggle register, flips the cycle after each Rise ----
        logic tog_p3;

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                tog_p3 <= 1'b0;
            end else if (rise_p2) begin
                tog_p3 <= ~tog_p3;
            end
        end

        assign Tog[i] = tog_p3;
`else
        assign Tog[i] = 1'b0;
`endif
    end

endmodule
